// File: rtl/start_sequencer.sv
// Pulse start sequencer: waits for TIME_START, then runs N_IMPULS cycles of
// BLANK1 -> TI (emit) -> BLANK2 -> TP (receive) with registered enables.
module start_sequencer (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [63:0] SYS_TIME,
    input  logic        ARM,
    input  logic        ABORT,
    input  logic [47:0] TIME_START,
    input  logic [15:0] N_IMPULS,
    input  logic [31:0] T_TI,
    input  logic [31:0] T_TP,
    input  logic [31:0] T_BLANK1,
    input  logic [31:0] T_BLANK2,
    output logic        EN_IZ,
    output logic        EN_PR,
    output logic        DDS_START,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR_PARAM,
    output logic        ERR_LATE,
    output logic        ERR_BUSY,
    output logic [15:0] PULSE_CNT
);

    typedef enum logic [2:0] {IDLE, WAIT_T, BLANK1, TI, BLANK2, TP} state_t;

    state_t      state, state_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic [47:0] start_q;
    logic [15:0] n_q;
    logic [31:0] ti_q, tp_q, b1_q, b2_q;
    logic        load, cnt_inc, done_nxt, ep_nxt, el_nxt, eb_nxt;
    logic [47:0] now;
    logic        unused_sys_hi;

    assign now           = SYS_TIME[47:0];
    assign unused_sys_hi = ^SYS_TIME[63:48];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        cnt_inc   = 1'b0;
        done_nxt  = 1'b0;
        ep_nxt    = 1'b0;
        el_nxt    = 1'b0;
        eb_nxt    = 1'b0;
        if (ABORT) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (ARM) begin
                    if (N_IMPULS == 16'd0 || T_TI == 32'd0 || T_TP == 32'd0)
                        ep_nxt = 1'b1;
                    else if (TIME_START <= now)
                        el_nxt = 1'b1;
                    else begin
                        load      = 1'b1;
                        state_nxt = WAIT_T;
                    end
                end
                WAIT_T: if (now >= start_q) begin
                    // zero-length blanks fall straight through to the next phase
                    if (b1_q == 32'd0) begin state_nxt = TI;     cnt_nxt = ti_q; end
                    else               begin state_nxt = BLANK1; cnt_nxt = b1_q; end
                end
                BLANK1: begin
                    if (cnt == 32'd1) begin state_nxt = TI; cnt_nxt = ti_q; end
                    else cnt_nxt = cnt - 32'd1;
                end
                TI: begin
                    if (cnt == 32'd1) begin
                        if (b2_q == 32'd0) begin state_nxt = TP;     cnt_nxt = tp_q; end
                        else               begin state_nxt = BLANK2; cnt_nxt = b2_q; end
                    end else cnt_nxt = cnt - 32'd1;
                end
                BLANK2: begin
                    if (cnt == 32'd1) begin state_nxt = TP; cnt_nxt = tp_q; end
                    else cnt_nxt = cnt - 32'd1;
                end
                TP: begin
                    if (cnt == 32'd1) begin
                        cnt_inc = 1'b1;
                        if ({1'b0, PULSE_CNT} + 17'd1 < {1'b0, n_q}) begin
                            if (b1_q == 32'd0) begin state_nxt = TI;     cnt_nxt = ti_q; end
                            else               begin state_nxt = BLANK1; cnt_nxt = b1_q; end
                        end else begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end
                    end else cnt_nxt = cnt - 32'd1;
                end
                default: state_nxt = IDLE;
            endcase
            if (ARM && state != IDLE)
                eb_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            start_q   <= '0;
            n_q       <= '0;
            ti_q      <= '0;
            tp_q      <= '0;
            b1_q      <= '0;
            b2_q      <= '0;
            EN_IZ     <= 1'b0;
            EN_PR     <= 1'b0;
            DDS_START <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERR_PARAM <= 1'b0;
            ERR_LATE  <= 1'b0;
            ERR_BUSY  <= 1'b0;
            PULSE_CNT <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load) begin
                start_q   <= TIME_START;
                n_q       <= N_IMPULS;
                ti_q      <= T_TI;
                tp_q      <= T_TP;
                b1_q      <= T_BLANK1;
                b2_q      <= T_BLANK2;
                PULSE_CNT <= '0;
            end else if (cnt_inc) begin
                PULSE_CNT <= PULSE_CNT + 16'd1;
            end
            // outputs are registered from the next state so they align with it
            EN_IZ     <= (state_nxt == TI);
            EN_PR     <= (state_nxt == TP);
            DDS_START <= (state_nxt == TI) && (state != TI);
            BUSY      <= (state_nxt != IDLE);
            DONE      <= done_nxt;
            ERR_PARAM <= ep_nxt;
            ERR_LATE  <= el_nxt;
            ERR_BUSY  <= eb_nxt;
        end
    end

endmodule
